// File: rtl/ram.sv
// rtl/ram.sv - 2^ADDR_W x DATA_W register-array RAM, write-first, combinational read
module ram #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ram_ena,
    input  logic              wena,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wr_en;

    assign w_wr_en = ram_ena & wena;

    // Reset clears the whole array asynchronously, so a write racing reset is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_mem[addr] <= data_in;
        end
    end

    // Read path is live in both read and write cycles; idle or reset forces zero.
    assign data_out = (rst_n && ram_ena) ? r_mem[addr] : '0;

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed self-checking bench for ram
module tb_ram;

    logic        clk;
    logic        rst_n;
    logic        ram_ena;
    logic        wena;
    logic [4:0]  addr;
    logic [31:0] data_in;
    logic [31:0] data_out;

    int n_cmp;
    int n_bad;

    ram #(.ADDR_W(5), .DATA_W(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ram_ena  (ram_ena),
        .wena     (wena),
        .addr     (addr),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        ram_ena = 1'b1;
        wena    = 1'b1;
        addr    = a;
        data_in = d;
        @(posedge clk);
        #1;
        chk("write_first", data_out, d);
    endtask

    task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] exp);
        @(negedge clk);
        ram_ena = 1'b1;
        wena    = 1'b0;
        addr    = a;
        #1;
        chk(tag, data_out, exp);
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        ram_ena = 1'b0;
        wena    = 1'b0;
        addr    = '0;
        data_in = '0;

        // power-up idle under reset
        #100;
        chk("powerup_idle", data_out, 32'h0);
        ram_ena = 1'b1;
        #1;
        chk("reset_read_zero", data_out, 32'h0);
        ram_ena = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;
        rd("powerup_mem0", 5'd0, 32'h0);
        rd("powerup_mem31", 5'd31, 32'h0);

        // asynchronous reset mid-cycle
        wr(5'd3, 32'hDEAD_BEEF);
        rd("pre_reset_addr3", 5'd3, 32'hDEAD_BEEF);
        @(negedge clk);
        ram_ena = 1'b1;
        wena    = 1'b1;
        addr    = 5'd4;
        data_in = 32'hCAFE_F00D;
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_async_out", data_out, 32'h0);
        @(posedge clk);
        @(negedge clk);
        wena  = 1'b0;
        rst_n = 1'b1;
        addr  = 5'd3;
        #1;
        chk("reset_cleared_addr3", data_out, 32'h0);
        addr = 5'd4;
        #1;
        chk("reset_discard_addr4", data_out, 32'h0);

        // write all then read all
        for (int i = 0; i < 32; i++) begin
            wr(5'(i), 32'(i) * 32'h0101_0101);
        end
        for (int i = 0; i < 32; i++) begin
            rd($sformatf("readback_%0d", i), 5'(i), 32'(i) * 32'h0101_0101);
        end

        // disabled write
        @(negedge clk);
        ram_ena = 1'b0;
        wena    = 1'b1;
        addr    = 5'd5;
        data_in = 32'h1234_5678;
        #1;
        chk("disabled_out_zero", data_out, 32'h0);
        @(posedge clk);
        #1;
        chk("disabled_out_after_edge", data_out, 32'h0);
        rd("disabled_addr5_kept", 5'd5, 32'h0505_0505);

        // combinational address switch
        wr(5'd7, 32'hA5A5_A5A5);
        wr(5'd8, 32'h5A5A_5A5A);
        rd("comb_addr7", 5'd7, 32'hA5A5_A5A5);
        #1;
        addr = 5'd8;
        #1;
        chk("comb_addr8", data_out, 32'h5A5A_5A5A);

        // back-to-back overwrite of addr 31
        wr(5'd31, 32'h1111_1111);
        @(negedge clk);
        data_in = 32'h2222_2222;
        #1;
        chk("overwrite_before_edge", data_out, 32'h1111_1111);
        @(posedge clk);
        #1;
        chk("overwrite_after_edge", data_out, 32'h2222_2222);
        rd("overwrite_readback", 5'd31, 32'h2222_2222);
        rd("neighbour_addr30", 5'd30, 32'h1E1E_1E1E);

        @(negedge clk);
        ram_ena = 1'b0;
        wena    = 1'b0;
        #1;
        chk("idle_out_zero", data_out, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram.md
RAM -- requirements
Module: ram

Interface
REQ-001 Parameter ADDR_W, default 5, address width; depth SHALL be 2^ADDR_W words (32).
REQ-002 Parameter DATA_W, default 32, word width in bits.
REQ-003 clk  input  1  single clock; all state changes SHALL occur on its rising edge, except reset.
REQ-004 rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 ram_ena  input  1  chip enable; 1 = access allowed, 0 = block idle.
REQ-006 wena  input  1  write enable; 1 = write, 0 = read; SHALL be qualified by ram_ena.
REQ-007 addr  input  ADDR_W  word address, 0..31.
REQ-008 data_in  input  DATA_W  write data.
REQ-009 data_out  output  DATA_W  read data.

Function
REQ-010 Storage SHALL be a 32 x 32-bit array of registers, one word per address, with no byte enables.
REQ-011 Write: at a rising clk edge with rst_n=1, ram_ena=1 and wena=1, mem[addr] SHALL take the value of data_in.
REQ-012 No memory word SHALL change when ram_ena=0, regardless of wena, addr or data_in.
REQ-013 Read SHALL be combinational with zero-cycle latency: when ram_ena=1 and wena=0, data_out SHALL equal mem[addr].
REQ-014 When ram_ena=1 and wena=1, data_out SHALL equal the current contents of mem[addr]:
- before the write edge, the old value;
- after the edge, the newly written value (write-first is visible from the same cycle onward).
REQ-015 When ram_ena=0, data_out SHALL be driven to 0; it SHALL never be high-impedance or X.
REQ-016 A change of addr while reading SHALL update data_out in the same delta/cycle, without waiting for a clock edge.
REQ-017 Every address 0..31 SHALL be valid; there is no out-of-range condition and no address wrap logic.
REQ-018 Back-to-back writes on consecutive cycles to the same or different addresses SHALL each complete; the last write to an address wins.
REQ-019 Inputs SHALL be sampled only at the rising edge for writes; glitches between edges SHALL NOT alter memory.

Reset
REQ-020 Asserting rst_n low SHALL immediately, without a clock edge, clear all 32 words to 32'h0000_0000.
REQ-021 While rst_n=0, writes SHALL be blocked and data_out SHALL read 0.
REQ-022 A write in progress when reset is asserted SHALL be discarded.
REQ-023 Deassertion of rst_n SHALL be treated synchronously by the bench: the first write takes effect at the first rising edge after rst_n=1.

Verification
REQ-024 Reset check: write 32'hDEAD_BEEF to addr 3, pulse rst_n low mid-cycle, then read addr 3 with ram_ena=1, wena=0 -> data_out=0 immediately.
REQ-025 Write/read all: write addr*32'h0101_0101 to addr 0..31, then read back each address -> exact match, including addr 0 = 0 and addr 31 = 32'h1F1F_1F1F.
REQ-026 Disabled write: ram_ena=0, wena=1, addr=5, data_in=32'h1234_5678 for one edge; then read addr 5 -> previous value unchanged; data_out=0 while ram_ena=0.
REQ-027 Combinational read: with addr 7 holding 32'hA5A5_A5A5 and addr 8 holding 32'h5A5A_5A5A, switch addr 7->8 between clock edges -> data_out follows to 32'h5A5A_5A5A with no edge.
REQ-028 Overwrite: write 32'h1111_1111 then, next cycle, 32'h2222_2222 to addr 31 -> data_out shows 32'h2222_2222 from the second write edge onward.
REQ-029 Initial state after power-up: ram_ena=0, wena=0, addr=0, data_in=0 held for 100 ns with reset applied -> data_out=0 and no memory writes.
